// File: rtl/pulse_width_checker_if.sv
// Pulse-line and measurement-result bundle for pulse_width_checker.
// master = stimulus/consumer side, slave = the checker itself.
interface pulse_width_checker_if #(
    parameter int CW = 4
);
    logic          pulse_in;
    logic          clr_err;
    logic [CW-1:0] width_out;
    logic          width_valid;
    logic          match;
    logic          short_err;
    logic          long_err;
    logic          busy;

    modport master (
        output pulse_in, clr_err,
        input  width_out, width_valid, match, short_err, long_err, busy
    );

    modport slave (
        input  pulse_in, clr_err,
        output width_out, width_valid, match, short_err, long_err, busy
    );
endinterface

// File: rtl/pulse_width_checker.sv
// Measures the high time of pulse_in in clk cycles, strobes the result and keeps sticky short/long flags.
// Define PWCHK_SYNC_EN to pass pulse_in through a two-flop synchronizer first (+2 cycles of latency).
//
// state | meaning
// IDLE  | waiting for the sampled line to go high
// MEAS  | line high, counting cycles
// OVF   | width counter saturated, waiting for the line to drop
module pulse_width_checker #(
    parameter int CW        = 4,
    parameter int EXP_WIDTH = 6
) (
    input logic                  clk,
    input logic                  rst,
    pulse_width_checker_if.slave bus
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] EXP     = CW'(EXP_WIDTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        OVF
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s;

`ifdef PWCHK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.pulse_in};
        end
    end

    assign s = sync_q[1];
`else
    assign s = bus.pulse_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.width_out   <= '0;
            bus.width_valid <= 1'b0;
            bus.match       <= 1'b0;
            bus.short_err   <= 1'b0;
            bus.long_err    <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.width_valid <= 1'b0;
            // Clear first so that any set below on the same edge takes priority.
            if (bus.clr_err) begin
                bus.short_err <= 1'b0;
                bus.long_err  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (s) begin
                        state    <= MEAS;
                        cnt      <= ONE;
                        bus.busy <= 1'b1;
                    end
                end
                MEAS: begin
                    if (s) begin
                        if (cnt == CNT_MAX) begin
                            state        <= OVF;
                            bus.long_err <= 1'b1;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end else begin
                        state           <= IDLE;
                        bus.busy        <= 1'b0;
                        bus.width_out   <= cnt;
                        bus.width_valid <= 1'b1;
                        bus.match       <= (cnt == EXP);
                        if (cnt < EXP) begin
                            bus.short_err <= 1'b1;
                        end
                        if (cnt > EXP) begin
                            bus.long_err <= 1'b1;
                        end
                    end
                end
                OVF: begin
                    if (!s) begin
                        state           <= IDLE;
                        bus.busy        <= 1'b0;
                        bus.width_out   <= CNT_MAX;
                        bus.width_valid <= 1'b1;
                        bus.match       <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
